score_keeper: RTL

- Upstream of the score-to-digit splitter.
- Accumulates game score, cleared-line count and level from line-clear and drop events issued by the playfield/clear-detection logic.
- Drives the 14-bit Score consumed by the digit splitter, plus Level for the gravity-speed stage.
- Points scale with level via a multi-cycle repeated-add FSM; line-clear events use a valid/ready handshake.

---
 rtl/score_pkg.sv | 51 +++++
 rtl/score_keeper.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper: FSM states, line-clear base points,
// saturation limits and the saturating score adder.
package score_pkg;

   localparam int unsigned MAX_SCORE       = 9999;
   localparam int unsigned MAX_LINES       = 999;
   localparam int unsigned MAX_LEVEL       = 15;
   localparam int unsigned LINES_PER_LEVEL = 10;

   localparam int SCORE_W = 14;
   localparam int LINES_W = 10;
   localparam int LEVEL_W = 4;
   localparam int BASE_W  = 11;

   localparam logic [BASE_W-1:0] BASE_SINGLE = 11'd40;
   localparam logic [BASE_W-1:0] BASE_DOUBLE = 11'd100;
   localparam logic [BASE_W-1:0] BASE_TRIPLE = 11'd300;
   localparam logic [BASE_W-1:0] BASE_TETRIS = 11'd1200;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ADD_PTS   = 2'd1,
      UPD_LINES = 2'd2
   } state_t;

   // 15-bit intermediate: MAX_SCORE plus the largest addend cannot overflow it.
   function automatic logic [SCORE_W-1:0] sat_add_score(input logic [SCORE_W-1:0] a,
                                                        input logic [BASE_W-1:0]  b);
      logic [SCORE_W:0] sum;
      sum = {1'b0, a} + {4'b0, b};
      if (sum > 15'(MAX_SCORE)) begin
         return 14'(MAX_SCORE);
      end
      return sum[SCORE_W-1:0];
   endfunction

   function automatic logic clear_legal(input logic [2:0] n);
      return (n != 3'd0) && (n <= 3'd4);
   endfunction

   function automatic logic [BASE_W-1:0] base_points(input logic [2:0] n);
      case (n)
         3'd1:    return BASE_SINGLE;
         3'd2:    return BASE_DOUBLE;
         3'd3:    return BASE_TRIPLE;
         3'd4:    return BASE_TETRIS;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/score_keeper.sv
// Score/lines/level accumulator: a clear takes Level+3 cycles to ready (Level+1 repeated adds, one line
// update); drops finish in one cycle. ready is high only in IDLE, so both event sources stall while busy.
module score_keeper
   import score_pkg::*;
(
   input  logic               Clk,
   input  logic               Reset,
   input  logic               reset_game,
   input  logic               clear_valid,
   input  logic [2:0]         clear_count,
   input  logic               drop_valid,
   input  logic [4:0]         drop_rows,
   output logic               ready,
   output logic [SCORE_W-1:0] Score,
   output logic [LINES_W-1:0] Lines,
   output logic [LEVEL_W-1:0] Level,
   output logic               level_up,
   output logic               score_update
);

   state_t               state_q, state_d;
   logic [BASE_W-1:0]    base_q, base_d;
   logic [2:0]           cnt_q, cnt_d;
   logic [LEVEL_W-1:0]   iter_q, iter_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [LINES_W-1:0]   lines_q, lines_d;
   logic [LEVEL_W-1:0]   level_q, level_d;
   logic [3:0]           lil_q, lil_d;
   logic                 level_up_q, level_up_d;
   logic                 score_update_q, score_update_d;

   logic [LINES_W:0]     lines_sum;
   logic [4:0]           lil_sum;
   logic [4:0]           lil_wrap;
   logic                 clear_ok;

   always_comb begin
      state_d        = state_q;
      base_d         = base_q;
      cnt_d          = cnt_q;
      iter_d         = iter_q;
      score_d        = score_q;
      lines_d        = lines_q;
      level_d        = level_q;
      lil_d          = lil_q;
      level_up_d     = 1'b0;
      score_update_d = 1'b0;

      lines_sum = {1'b0, lines_q} + {8'b0, cnt_q};
      lil_sum   = {1'b0, lil_q} + {2'b0, cnt_q};
      lil_wrap  = lil_sum - 5'(LINES_PER_LEVEL);
      clear_ok  = clear_valid && clear_legal(clear_count);

      if (reset_game) begin
         state_d = IDLE;
         base_d  = '0;
         cnt_d   = '0;
         iter_d  = '0;
         score_d = '0;
         lines_d = '0;
         level_d = '0;
         lil_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               // A drop shares the acceptance cycle with a clear; the clear owns the completion pulse.
               if (drop_valid) begin
                  score_d        = sat_add_score(score_q, {6'b0, drop_rows});
                  score_update_d = !clear_ok;
               end
               if (clear_ok) begin
                  base_d  = base_points(clear_count);
                  cnt_d   = clear_count;
                  iter_d  = level_q;
                  state_d = ADD_PTS;
               end
            end

            ADD_PTS: begin
               score_d = sat_add_score(score_q, base_q);
               if (iter_q == '0) begin
                  state_d = UPD_LINES;
               end else begin
                  iter_d = iter_q - 1'b1;
               end
            end

            UPD_LINES: begin
               lines_d = (lines_sum > 11'(MAX_LINES)) ? 10'(MAX_LINES) : lines_sum[LINES_W-1:0];
               if (lil_sum >= 5'(LINES_PER_LEVEL)) begin
                  lil_d = lil_wrap[3:0];
                  if (level_q < 4'(MAX_LEVEL)) begin
                     level_d    = level_q + 1'b1;
                     level_up_d = 1'b1;
                  end
               end else begin
                  lil_d = lil_sum[3:0];
               end
               score_update_d = 1'b1;
               state_d        = IDLE;
            end

            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q        <= IDLE;
         base_q         <= '0;
         cnt_q          <= '0;
         iter_q         <= '0;
         score_q        <= '0;
         lines_q        <= '0;
         level_q        <= '0;
         lil_q          <= '0;
         level_up_q     <= 1'b0;
         score_update_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         base_q         <= base_d;
         cnt_q          <= cnt_d;
         iter_q         <= iter_d;
         score_q        <= score_d;
         lines_q        <= lines_d;
         level_q        <= level_d;
         lil_q          <= lil_d;
         level_up_q     <= level_up_d;
         score_update_q <= score_update_d;
      end
   end

   assign ready        = (state_q == IDLE);
   assign Score        = score_q;
   assign Lines        = lines_q;
   assign Level        = level_q;
   assign level_up     = level_up_q;
   assign score_update = score_update_q;

endmodule
